prog_counter: RTL and testbench
===============================

Name: prog_counter

Overview:
- Parametrised successor to the single-channel start-and-wrap counter used in the single_cycle design for timing, display multiplexing and debounce windows.
- Adds width parameter, up/down direction, one-shot or wrap mode, pause/stop/clear control, a latched terminal value and a terminal-count pulse.
- Sits beside the datapath as a general timing source. Driven by board buttons or control logic; outputs feed display and strobe logic.

Parameters:
- WIDTH, 30, counter and terminal-value width in bits.
- PRESCALE_W, 16, prescaler divider width; used only with PROG_COUNTER_PRESCALE_EN.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  level-sampled; accepted in IDLE or DONE.
- stop  input  1  abort to IDLE; cnt holds its value.
- pause  input  1  while high in RUN/HOLD, counting freezes.
- clear  input  1  forces cnt to 0 and returns to IDLE.
- dir_down  input  1  0 = count up, 1 = count down; sampled at start.
- oneshot  input  1  0 = wrap mode, 1 = one-shot mode; sampled at start.
- cnt_max  input  WIDTH  terminal value; sampled at start into max_q.
- cnt  output  WIDTH  current count.
- tc  output  1  one-cycle terminal-count pulse.
- running  output  1  high in RUN or HOLD.
- done  output  1  high in DONE.

Behaviour:
- Single clock, clk. Reset is rst_n: synchronous, active-low.
- Reset values: state = IDLE; cnt, max_q, dir_q, oneshot_q, tc, running and done all 0.
- Priority per edge, highest first: rst_n low > clear > stop > start > pause > count.
- States: IDLE, RUN, HOLD, DONE. running and done are registered decodes of the next state.
- IDLE:
  - start -> RUN.
  - Same edge: max_q <= cnt_max, dir_q <= dir_down, oneshot_q <= oneshot.
  - Same edge: cnt <= (dir_down ? cnt_max : 0). The first increment or decrement occurs on the following tick.
- RUN:
  - pause high -> HOLD. No count on that edge.
  - Otherwise one step per tick (tick = every cycle unless the prescaler is enabled).
  - Terminal value is max_q when counting up, 0 when counting down.
  - On a tick with cnt at terminal, wrap mode: cnt reloads (up -> 0, down -> max_q) and the state stays RUN.
  - On a tick with cnt at terminal, one-shot mode: cnt holds and the state goes to DONE.
  - Either way, tc <= 1 on that edge. tc is high exactly one cycle and otherwise 0.
- HOLD: cnt frozen; pause low -> RUN. No tc can fire in HOLD.
- DONE: cnt holds at terminal. start re-arms exactly as from IDLE, re-sampling all three inputs.
- stop in RUN/HOLD/DONE -> IDLE with cnt held. A later start reloads cnt.
- clear in any state -> IDLE with cnt <= 0.
- start while in RUN/HOLD is ignored. A restart requires stop or clear first.
- cnt_max = 0: up mode, every tick is terminal and tc pulses every tick in wrap mode. Down mode behaves identically.
- cnt_max changes after start have no effect until the next start.
- Arithmetic is modulo 2^WIDTH. No overflow is possible, because terminal detection precedes increment past max_q.
- rst_n low mid-count wins over every other input and returns all reset values on that edge.

Optional Feature:
- Macro: PROG_COUNTER_PRESCALE_EN.
- When defined:
  - Adds input prescale_div [PRESCALE_W-1:0]. A tick occurs every prescale_div+1 cycles.
  - The prescaler counter clears on start, stop, clear and reset.
  - It freezes in HOLD and resumes from its frozen value.
  - prescale_div is sampled at start.
- When undefined: the port is absent and tick = 1 every cycle in RUN.

Decomposition:
- Package prog_counter_pkg holds:
  - state typedef, enum of IDLE, RUN, HOLD, DONE with 2-bit encoding;
  - default WIDTH and PRESCALE_W localparams.
- One natural sub-module: tick_gen, the prescaler producing the tick strobe.
  - Instantiated only under PROG_COUNTER_PRESCALE_EN.
  - Otherwise tick is tied high.

Test Plan:
- Wrap, up: cnt_max=3, oneshot=0, dir_down=0, start pulse at cycle 0.
  - Required: cnt = 0,1,2,3,0,1,...
  - Required: tc high in the cycle cnt returns to 0, every 4 cycles; running=1.
- One-shot, down: cnt_max=5, oneshot=1, dir_down=1, start.
  - Required: cnt = 5,4,3,2,1,0 then holds at 0.
  - Required: a single tc, done=1, running=0; a second start reloads 5 and clears done.
- Pause: up, cnt_max=10. Assert pause at cnt=4 for 3 cycles.
  - Required: cnt stays 4 for those 3 cycles, no tc, then resumes at 5.
- Priority: assert clear, stop and start together in RUN at cnt=7.
  - Required next cycle: cnt=0, state IDLE, running=0.
  - Then: stop alone at cnt=2 leaves cnt=2 in IDLE.
- Sampling and reset: change cnt_max from 3 to 9 mid-run.
  - Required: wrap still occurs at 3.
  - Drive rst_n low at cnt=2. Required next edge: all outputs 0 and IDLE.
  - Required: a start held during reset is ignored.
- Prescale, with PROG_COUNTER_PRESCALE_EN: prescale_div=2, cnt_max=2, wrap, up.
  - Required: cnt advances every 3 cycles; tc period 9 cycles.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg
// Shared types and default sizes for the programmable counter slice.
//   state_t            : controller state, 2-bit encoding (IDLE, RUN, HOLD, DONE)
//   DEFAULT_WIDTH      : default counter / terminal-value width
//   DEFAULT_PRESCALE_W : default prescaler divider width
// The prescaler itself is only built when PROG_COUNTER_PRESCALE_EN is defined.
package prog_counter_pkg;

  localparam int DEFAULT_WIDTH      = 30;
  localparam int DEFAULT_PRESCALE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/prog_counter_tick_gen.sv
// tick_gen
// Prescaler that turns the run-enable into a tick strobe once every
// (divider + 1) enabled cycles. Only instantiated by prog_counter when
// PROG_COUNTER_PRESCALE_EN is defined.
// Ports:
//   i_clk     : system clock, rising edge
//   i_rst_n   : synchronous active-low reset
//   i_clear   : zero the prescale count (start accepted, stop, clear)
//   i_load    : capture i_div as the divider (start accepted)
//   i_div     : divider value; a tick every i_div+1 enabled cycles
//   i_enable  : counting permitted this cycle; when low the count freezes
//   o_tick    : strobe, high on the enabled cycle that completes a period
module tick_gen
  import prog_counter_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [PRESCALE_W-1:0] i_div,
  input  logic                  i_enable,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] r_pcnt;

  // The tick lands on the last cycle of each period, so the very first
  // tick after a start comes i_div+1 enabled cycles later.
  assign o_tick = i_enable && (r_pcnt == r_div);

  // Divider capture and period count. Holding i_enable low (pause) leaves
  // r_pcnt untouched so the period resumes where it left off.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div  <= '0;
      r_pcnt <= '0;
    end else begin
      if (i_load) begin
        r_div <= i_div;
      end
      if (i_clear) begin
        r_pcnt <= '0;
      end else if (i_enable) begin
        r_pcnt <= o_tick ? '0 : r_pcnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_counter.sv
// prog_counter
// Programmable up/down timing counter with wrap or one-shot behaviour,
// pause/stop/clear control, a start-latched terminal value and a one-cycle
// terminal-count pulse.
// Optional build macro: PROG_COUNTER_PRESCALE_EN adds the prescale_div input
// and a prescaler so counting advances once every prescale_div+1 cycles.
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   start        : arm and load the counter (accepted in IDLE or DONE)
//   stop         : return to IDLE, cnt keeps its value
//   pause        : freeze counting while high in RUN/HOLD
//   clear        : return to IDLE with cnt = 0
//   dir_down     : 0 counts up, 1 counts down (sampled at start)
//   oneshot      : 0 wraps, 1 stops in DONE at terminal (sampled at start)
//   cnt_max      : terminal value (sampled at start)
//   prescale_div : prescaler divider (PROG_COUNTER_PRESCALE_EN only)
//   cnt          : current count
//   tc           : one-cycle terminal-count pulse
//   running      : high in RUN or HOLD
//   done         : high in DONE
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  clear,
  input  logic                  dir_down,
  input  logic                  oneshot,
  input  logic [WIDTH-1:0]      cnt_max,
`ifdef PROG_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div,
`endif
  output logic [WIDTH-1:0]      cnt,
  output logic                  tc,
  output logic                  running,
  output logic                  done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_maxQ;
  logic             r_dirQ;
  logic             r_oneshotQ;
  logic             r_tc;
  logic             r_running;
  logic             r_done;

  state_t           w_stateNext;
  logic [WIDTH-1:0] w_cntNext;
  logic             w_tcNext;
  logic             w_startAcc;
  logic             w_atTerm;
  logic             w_tick;

  // Terminal is max_q going up and zero going down; it is checked before
  // stepping, so the count never runs past max_q.
  assign w_atTerm = r_dirQ ? (r_cnt == '0) : (r_cnt == r_maxQ);

`ifdef PROG_COUNTER_PRESCALE_EN
  logic w_tickEn;

  // The prescaler only advances on cycles where the counter would step.
  assign w_tickEn = (r_state == RUN || r_state == HOLD) && !pause && !clear && !stop;

  tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clear  (w_startAcc || clear || stop),
    .i_load   (w_startAcc),
    .i_div    (prescale_div),
    .i_enable (w_tickEn),
    .o_tick   (w_tick)
  );
`else
  logic [PRESCALE_W-1:0] w_unusedPrescale;

  // PRESCALE_W only sizes the prescaler; without it every cycle is a tick.
  assign w_unusedPrescale = '0;
  assign w_tick           = 1'b1;
`endif

  // Next-state and next-count decode. clear beats stop beats start beats
  // pause. Leaving HOLD steps on the same edge as an ordinary RUN cycle, so
  // the count is frozen for exactly the cycles pause is sampled high.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_tcNext    = 1'b0;
    w_startAcc  = 1'b0;
    if (clear) begin
      w_stateNext = IDLE;
      w_cntNext   = '0;
    end else if (stop) begin
      w_stateNext = IDLE;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_stateNext = RUN;
            w_startAcc  = 1'b1;
            w_cntNext   = dir_down ? cnt_max : '0;
          end
        end
        RUN, HOLD: begin
          if (pause) begin
            w_stateNext = HOLD;
          end else begin
            w_stateNext = RUN;
            if (w_tick) begin
              if (w_atTerm) begin
                w_tcNext = 1'b1;
                if (r_oneshotQ) begin
                  w_stateNext = DONE;
                end else begin
                  w_cntNext = r_dirQ ? r_maxQ : '0;
                end
              end else begin
                w_cntNext = r_dirQ ? (r_cnt - WIDTH'(1)) : (r_cnt + WIDTH'(1));
              end
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // State, count and registered status outputs. running/done decode the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_maxQ     <= '0;
      r_dirQ     <= 1'b0;
      r_oneshotQ <= 1'b0;
      r_tc       <= 1'b0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_tc      <= w_tcNext;
      r_running <= (w_stateNext == RUN) || (w_stateNext == HOLD);
      r_done    <= (w_stateNext == DONE);
      if (w_startAcc) begin
        r_maxQ     <= cnt_max;
        r_dirQ     <= dir_down;
        r_oneshotQ <= oneshot;
      end
    end
  end

  assign cnt     = r_cnt;
  assign tc      = r_tc;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter
// Directed bench for prog_counter. Each stimulus cycle pushes the hand-derived
// outputs expected after the following rising edge; a separate monitor pops
// and compares one entry per edge.
// With PROG_COUNTER_PRESCALE_EN defined, the prescaler sequence is added.
module tb_prog_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         pause;
  logic         clear;
  logic         dir_down;
  logic         oneshot;
  logic [W-1:0] cnt_max;
  logic [W-1:0] cnt;
  logic         tc;
  logic         running;
  logic         done;
`ifdef PROG_COUNTER_PRESCALE_EN
  logic [PW-1:0] prescale_div;
`endif

  int total = 0;
  int bad   = 0;

  string        nmQ[$];
  logic [W+2:0] expQ[$];

  always #5 clk = ~clk;

  prog_counter #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .clear        (clear),
    .dir_down     (dir_down),
    .oneshot      (oneshot),
    .cnt_max      (cnt_max),
`ifdef PROG_COUNTER_PRESCALE_EN
    .prescale_div (prescale_div),
`endif
    .cnt          (cnt),
    .tc           (tc),
    .running      (running),
    .done         (done)
  );

  // Drive one cycle of inputs, away from the rising edge.
  task automatic applyStimulus(input logic r, s, sp, p, c, d, o, input logic [W-1:0] m);
    @(negedge clk);
    rst_n    = r;
    start    = s;
    stop     = sp;
    pause    = p;
    clear    = c;
    dir_down = d;
    oneshot  = o;
    cnt_max  = m;
  endtask

  // Queue what the outputs must be just after the next rising edge.
  task automatic checkOutput(input string nm, input logic [W-1:0] c, input logic t, ru, dn);
    nmQ.push_back(nm);
    expQ.push_back({c, t, ru, dn});
  endtask

  task automatic cyc(input string nm, input logic r, s, sp, p, c, d, o,
                     input logic [W-1:0] m, input logic [W-1:0] ec,
                     input logic et, er, ed);
    applyStimulus(r, s, sp, p, c, d, o, m);
    checkOutput(nm, ec, et, er, ed);
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after it.
  initial begin
    logic [W+2:0] e;
    logic [W+2:0] a;
    string        n;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nmQ.pop_front();
        a = {cnt, tc, running, done};
        total++;
        if (a !== e) begin
          bad++;
          $display("[TB] FAIL %s: got cnt=%0d tc=%0b running=%0b done=%0b, want cnt=%0d tc=%0b running=%0b done=%0b",
                   n, a[W+2:3], a[2], a[1], a[0], e[W+2:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    dir_down = 1'b0;
    oneshot  = 1'b0;
    cnt_max  = '0;
`ifdef PROG_COUNTER_PRESCALE_EN
    prescale_div = '0;
`endif

    // Reset, including a start held while in reset
    cyc("reset_start_ignored", 0, 1, 0, 0, 0, 0, 0, 8'd3, 8'd0, 0, 0, 0);
    cyc("reset_state",         0, 0, 0, 0, 0, 0, 0, 8'd3, 8'd0, 0, 0, 0);
    cyc("idle_after_reset",    1, 0, 0, 0, 0, 0, 0, 8'd3, 8'd0, 0, 0, 0);

    // Wrap, up, cnt_max = 3
    cyc("wrap_load", 1, 1, 0, 0, 0, 0, 0, 8'd3, 8'd0, 0, 1, 0);
    for (int i = 1; i <= 9; i++)
      cyc("wrap_up", 1, 0, 0, 0, 0, 0, 0, 8'd3, W'(i % 4), (i % 4 == 0), 1, 0);
    // cnt_max moves to 9 mid-run; terminal stays at the sampled 3
    for (int i = 2; i <= 6; i++)
      cyc("maxq_sampled", 1, 0, 0, 0, 0, 0, 0, 8'd9, W'(i % 4), (i % 4 == 0), 1, 0);
    // Reset at cnt = 2 with start held high
    cyc("rst_mid_count",  0, 1, 0, 0, 0, 0, 0, 8'd9, 8'd0, 0, 0, 0);
    cyc("rst_hold_start", 0, 1, 0, 0, 0, 0, 0, 8'd9, 8'd0, 0, 0, 0);
    cyc("rst_release",    1, 0, 0, 0, 0, 0, 0, 8'd9, 8'd0, 0, 0, 0);

    // One-shot, down, cnt_max = 5
    cyc("os_load", 1, 1, 0, 0, 0, 1, 1, 8'd5, 8'd5, 0, 1, 0);
    for (int i = 4; i >= 0; i--)
      cyc("os_down", 1, 0, 0, 0, 0, 1, 1, 8'd5, W'(i), 0, 1, 0);
    cyc("os_tc",    1, 0, 0, 0, 0, 1, 1, 8'd5, 8'd0, 1, 0, 1);
    cyc("os_done",  1, 0, 0, 0, 0, 1, 1, 8'd5, 8'd0, 0, 0, 1);
    cyc("os_done2", 1, 0, 0, 0, 0, 1, 1, 8'd5, 8'd0, 0, 0, 1);
    cyc("os_rearm", 1, 1, 0, 0, 0, 1, 1, 8'd5, 8'd5, 0, 1, 0);
    cyc("os_step",  1, 0, 0, 0, 0, 1, 1, 8'd5, 8'd4, 0, 1, 0);
    cyc("os_stop",  1, 0, 1, 0, 0, 1, 1, 8'd5, 8'd4, 0, 0, 0);

    // Pause at cnt = 4 for three cycles, up, cnt_max = 10
    cyc("p_load", 1, 1, 0, 0, 0, 0, 0, 8'd10, 8'd0, 0, 1, 0);
    for (int i = 1; i <= 4; i++)
      cyc("p_count", 1, 0, 0, 0, 0, 0, 0, 8'd10, W'(i), 0, 1, 0);
    for (int k = 0; k < 3; k++)
      cyc("p_hold", 1, 0, 0, 1, 0, 0, 0, 8'd10, 8'd4, 0, 1, 0);
    cyc("p_resume", 1, 0, 0, 0, 0, 0, 0, 8'd10, 8'd5, 0, 1, 0);
    cyc("p_count6", 1, 0, 0, 0, 0, 0, 0, 8'd10, 8'd6, 0, 1, 0);
    cyc("p_count7", 1, 0, 0, 0, 0, 0, 0, 8'd10, 8'd7, 0, 1, 0);

    // clear + stop + start together at cnt = 7
    cyc("prio_all",  1, 1, 1, 0, 1, 0, 0, 8'd10, 8'd0, 0, 0, 0);
    cyc("prio_idle", 1, 0, 0, 0, 0, 0, 0, 8'd10, 8'd0, 0, 0, 0);
    // stop alone at cnt = 2 keeps the count
    cyc("stop_load", 1, 1, 0, 0, 0, 0, 0, 8'd10, 8'd0, 0, 1, 0);
    cyc("stop_c1",   1, 0, 0, 0, 0, 0, 0, 8'd10, 8'd1, 0, 1, 0);
    cyc("stop_c2",   1, 0, 0, 0, 0, 0, 0, 8'd10, 8'd2, 0, 1, 0);
    cyc("stop_only", 1, 0, 1, 0, 0, 0, 0, 8'd10, 8'd2, 0, 0, 0);
    cyc("stop_idle", 1, 0, 0, 0, 0, 0, 0, 8'd10, 8'd2, 0, 0, 0);

    // cnt_max = 0: every tick is terminal, up and down
    cyc("zero_up_load", 1, 1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      cyc("zero_up_tc", 1, 0, 0, 0, 0, 0, 0, 8'd0, 8'd0, 1, 1, 0);
    cyc("zero_clear", 1, 0, 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0);
    cyc("zero_dn_load", 1, 1, 0, 0, 0, 1, 0, 8'd0, 8'd0, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      cyc("zero_dn_tc", 1, 0, 0, 0, 0, 1, 0, 8'd0, 8'd0, 1, 1, 0);
    cyc("zero_dn_clear", 1, 0, 0, 0, 1, 1, 0, 8'd0, 8'd0, 0, 0, 0);

`ifdef PROG_COUNTER_PRESCALE_EN
    // Prescale: div = 2, cnt_max = 2, wrap up -> step every 3, tc every 9
    prescale_div = 4'd2;
    cyc("ps_load", 1, 1, 0, 0, 0, 0, 0, 8'd2, 8'd0, 0, 1, 0);
    for (int k = 1; k <= 18; k++)
      cyc("ps_run", 1, 0, 0, 0, 0, 0, 0, 8'd2, W'((k / 3) % 3), (k % 9 == 0), 1, 0);
    cyc("ps_clear", 1, 0, 0, 0, 1, 0, 0, 8'd2, 8'd0, 0, 0, 0);
`endif

    repeat (3) @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
